// File: rtl/fpu_pkg.sv
// ---------------------------------------------------------------------------
// fpu_pkg
//   Shared types and constants for the floating-point adder sharing logic.
//   fp32_t     : raw IEEE-754 single-precision word
//   FP32_*     : canonical special-value encodings
//   RSP_ID_W   : width of the requester tag carried in a response entry
//   rsp_t      : one response FIFO entry {id, res, ovf}
// ---------------------------------------------------------------------------
package fpu_pkg;

    typedef logic [31:0] fp32_t;

    localparam fp32_t FP32_QNAN    = 32'h7FC00000;
    localparam fp32_t FP32_POS_INF = 32'h7F800000;
    localparam fp32_t FP32_NEG_INF = 32'hFF800000;

    // Tag width of a response entry. It has to equal the arbiter's ID_W,
    // which is $clog2(NUM_REQ); 2 covers the standard four-requester build.
    localparam int RSP_ID_W = 2;

    typedef struct packed {
        logic [RSP_ID_W-1:0] id;
        fp32_t               res;
        logic                ovf;
    } rsp_t;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin grant logic. The pointer register
//   lives in the parent; this block only computes the grant for this cycle
//   and the pointer value that should follow it.
//   req_i     : per-requester valid
//   en_i      : when low, no grant is issued
//   ptr_i     : index with the highest priority this cycle
//   gnt_o     : one-hot grant (all zero when nothing is granted)
//   ptr_nxt_o : winner+1 (mod NUM_REQ), or ptr_i when nothing is granted
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               en_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [PTR_W-1:0]   ptr_nxt_o
);

    logic             found;
    logic [PTR_W-1:0] idx;

    // Walk the requesters starting at ptr_i and wrapping; the first valid
    // one wins and the pointer moves just past it.
    always_comb begin
        gnt_o     = '0;
        ptr_nxt_o = ptr_i;
        found     = 1'b0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = PTR_W'((int'(ptr_i) + k) % NUM_REQ);
            if (en_i && !found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                ptr_nxt_o  = PTR_W'((int'(idx) + 1) % NUM_REQ);
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_add_arbiter.sv
// ---------------------------------------------------------------------------
// fp_add_arbiter
//   Shares one fixed-latency fp32 adder between NUM_REQ requesters using a
//   round-robin grant. Results come back tagged with the requester ID
//   through a show-ahead response FIFO. A credit counter bounds the number
//   of operations in flight, so the FIFO can never overflow even though the
//   adder itself cannot stall.
//   clk, rst              : clock, asynchronous active-high reset
//   req_vld/req_a/req_b   : per-requester valid and packed operands
//   req_rdy               : one-hot grant (combinational)
//   add_a/add_b/add_vld   : registered issue to the adder
//   add_res/_vld/add_ovf  : adder result, ADD_LAT cycles after add_vld
//   rsp_vld/id/res/ovf    : head of the response FIFO
//   rsp_rdy               : pops the head when rsp_vld is high
// ---------------------------------------------------------------------------
module fp_add_arbiter
    import fpu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int ADD_LAT = 1,
    parameter int DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_vld,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    output logic [NUM_REQ-1:0]   req_rdy,
    output logic [31:0]          add_a,
    output logic [31:0]          add_b,
    output logic                 add_vld,
    input  logic [31:0]          add_res,
    input  logic                 add_res_vld,
    input  logic                 add_ovf,
    output logic                 rsp_vld,
    output logic [ID_W-1:0]      rsp_id,
    output logic [31:0]          rsp_res,
    output logic                 rsp_ovf,
    input  logic                 rsp_rdy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Grant / credit state
    logic [CNT_W-1:0]   outstanding_q, outstanding_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic               arb_en;
    logic [NUM_REQ-1:0] gnt;
    logic               accept;
    logic [ID_W-1:0]    acc_id;
    fp32_t              acc_a, acc_b;

    // Issue register and tag pipeline
    fp32_t              add_a_q, add_b_q;
    logic               add_vld_q;
    logic [ID_W-1:0]    issue_id_q;
    logic [ID_W-1:0]    tag_q [ADD_LAT];

    // Response FIFO
    rsp_t               fifo_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push, pop;
    rsp_t               wr_entry, head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Reset gates the grant so req_rdy is low for the whole reset pulse,
    // not only after the registers clear. A pop frees its credit only once
    // outstanding_q has updated, which keeps the grant path short.
    assign arb_en = !rst && (outstanding_q != CNT_W'(DEPTH));

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (ID_W)
    ) u_rr_arbiter (
        .req_i     (req_vld),
        .en_i      (arb_en),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (gnt),
        .ptr_nxt_o (rr_ptr_d)
    );

    assign req_rdy = gnt;
    assign accept  = |gnt;

    // Select the winning requester's operands and turn the one-hot grant
    // into a tag.
    always_comb begin
        acc_id = '0;
        acc_a  = '0;
        acc_b  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                acc_id = ID_W'(i);
                acc_a  = req_a[32*i +: 32];
                acc_b  = req_b[32*i +: 32];
            end
        end
    end

    // Credits cover every stage from the issue register to the FIFO head.
    always_comb begin
        outstanding_d = outstanding_q;
        case ({accept, pop})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    // Issue register: operands hold between accepts; add_vld is a
    // one-cycle strobe per accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            add_vld_q     <= 1'b0;
            add_a_q       <= '0;
            add_b_q       <= '0;
            issue_id_q    <= '0;
            rr_ptr_q      <= '0;
            outstanding_q <= '0;
        end else begin
            add_vld_q     <= accept;
            rr_ptr_q      <= rr_ptr_d;
            outstanding_q <= outstanding_d;
            if (accept) begin
                add_a_q    <= acc_a;
                add_b_q    <= acc_b;
                issue_id_q <= acc_id;
            end
        end
    end

    assign add_a   = add_a_q;
    assign add_b   = add_b_q;
    assign add_vld = add_vld_q;

    // The tag shifts every cycle; the last stage lines up with add_res_vld
    // because the adder has a fixed latency. Stale tags between results
    // are harmless since only add_res_vld writes the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < ADD_LAT; k++) tag_q[k] <= '0;
        end else begin
            tag_q[0] <= issue_id_q;
            for (int k = 1; k < ADD_LAT; k++) tag_q[k] <= tag_q[k-1];
        end
    end

    assign push        = add_res_vld;
    assign pop         = rsp_vld && rsp_rdy;
    assign wr_entry.id  = RSP_ID_W'(tag_q[ADD_LAT-1]);
    assign wr_entry.res = add_res;
    assign wr_entry.ovf = add_ovf;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Response FIFO storage. Entries are cleared on reset so the show-ahead
    // outputs read as zero until the first result lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) fifo_q[k] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= wr_entry;
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_d;
        end
    end

    assign head    = fifo_q[rd_ptr_q];
    assign rsp_vld = (count_q != '0);
    assign rsp_id  = ID_W'(head.id);
    assign rsp_res = head.res;
    assign rsp_ovf = head.ovf;

    // The credit limit guarantees a free slot for every result.
    a_no_fifo_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (count_q == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_fp_add_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fp_add_arbiter
//   Bench for fp_add_arbiter with a behavioural one-cycle fp32 adder, a
//   round-robin/credit reference model and a response scoreboard.
// ---------------------------------------------------------------------------
module tb_fp_add_arbiter;
    import fpu_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int DEPTH   = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [NUM_REQ-1:0]    reqVld;
    logic [NUM_REQ*32-1:0] reqA, reqB;
    logic [NUM_REQ-1:0]    reqRdy;
    logic [31:0]           addA, addB, addRes;
    logic                  addVld, addResVld, addOvf;
    logic                  rspVld, rspOvf, rspRdy;
    logic [ID_W-1:0]       rspId;
    logic [31:0]           rspRes;

    typedef struct {
        int          id;
        logic [31:0] res;
        logic        ovf;
    } expRsp_t;

    expRsp_t     expQ[$];
    int          gntLog[$];
    int          rspLog[$];
    int          compared    = 0;
    int          mismatched  = 0;
    int          acceptCount = 0;
    int          modelPtr    = 0;
    int          modelOut    = 0;
    logic        prevAccept  = 1'b0;
    logic [31:0] prevA, prevB;

    always #5 clk = ~clk;

    fp_add_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W),
        .ADD_LAT (1),
        .DEPTH   (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_vld     (reqVld),
        .req_a       (reqA),
        .req_b       (reqB),
        .req_rdy     (reqRdy),
        .add_a       (addA),
        .add_b       (addB),
        .add_vld     (addVld),
        .add_res     (addRes),
        .add_res_vld (addResVld),
        .add_ovf     (addOvf),
        .rsp_vld     (rspVld),
        .rsp_id      (rspId),
        .rsp_res     (rspRes),
        .rsp_ovf     (rspOvf),
        .rsp_rdy     (rspRdy)
    );

    // fp32 -> real, flushing denormals to zero.
    function automatic real fp32ToReal(input logic [31:0] x);
        logic [63:0] d;
        logic [7:0]  e;
        e = x[30:23];
        if (e == 8'd0)        d = {x[31], 63'd0};
        else if (e == 8'hFF)  d = {x[31], 11'h7FF, x[22:0], 29'd0};
        else                  d = {x[31], 11'(e) + 11'd896, x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    // Reference adder: {ovf, result}. Sums in double precision and
    // truncates back to single; inf/NaN results raise the flag.
    function automatic logic [32:0] refAdd(input logic [31:0] a, input logic [31:0] b);
        real         s;
        logic [63:0] d;
        logic [10:0] de;
        s  = fp32ToReal(a) + fp32ToReal(b);
        d  = $realtobits(s);
        de = d[62:52];
        if (de == 11'h7FF) begin
            if (d[51:0] != 52'd0) return {1'b1, FP32_QNAN};
            return {1'b1, d[63], 8'hFF, 23'd0};
        end
        if (de <= 11'd896)  return {1'b0, d[63], 31'd0};
        if (de >= 11'd1151) return {1'b1, d[63], 8'hFF, 23'd0};
        return {1'b0, d[63], 8'(de - 11'd896), d[51:29]};
    endfunction

    function automatic logic [31:0] randFp();
        int sel;
        sel = $urandom_range(0, 19);
        if (sel == 0) return FP32_POS_INF;
        if (sel == 1) return FP32_NEG_INF;
        if (sel == 2) return 32'h0000_0000;
        return {1'($urandom), 8'($urandom_range(110, 144)), 23'($urandom)};
    endfunction

    // Behavioural adder, one cycle of latency, shares the DUT reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addResVld <= 1'b0;
            addRes    <= '0;
            addOvf    <= 1'b0;
        end else begin
            addResVld        <= addVld;
            {addOvf, addRes} <= refAdd(addA, addB);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drive new inputs just after a rising edge; operands are refreshed
    // randomly for every requester each cycle.
    task automatic applyStimulus(input logic [NUM_REQ-1:0] vld, input logic rdy);
        @(posedge clk);
        #1;
        reqVld = vld;
        rspRdy = rdy;
        for (int i = 0; i < NUM_REQ; i++) begin
            reqA[32*i +: 32] = randFp();
            reqB[32*i +: 32] = randFp();
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        applyStimulus('0, 1'b1);
        @(negedge clk);
        #1;
        while ((expQ.size() != 0 || rspVld) && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("drain scoreboard empty", 32'(expQ.size()), 32'd0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " req_rdy"}, 32'(reqRdy), 32'd0);
        checkOutput({tag, " add_vld"}, 32'(addVld), 32'd0);
        checkOutput({tag, " add_a"},   addA,        32'd0);
        checkOutput({tag, " add_b"},   addB,        32'd0);
        checkOutput({tag, " rsp_vld"}, 32'(rspVld), 32'd0);
        checkOutput({tag, " rsp_id"},  32'(rspId),  32'd0);
        checkOutput({tag, " rsp_res"}, rspRes,      32'd0);
        checkOutput({tag, " rsp_ovf"}, 32'(rspOvf), 32'd0);
    endtask

    // Issue side: reference round-robin/credit model checks the grant and
    // the issue strobe, and every accept pushes its expected response.
    always @(negedge clk) begin : issueMonitor
        logic [NUM_REQ-1:0] expGnt;
        int                 gIdx;
        logic [32:0]        r;
        expRsp_t            e;
        if (rst) begin
            modelPtr   = 0;
            modelOut   = 0;
            prevAccept = 1'b0;
        end else begin
            expGnt = '0;
            gIdx   = -1;
            if (modelOut < DEPTH) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (gIdx < 0 && reqVld[(modelPtr + k) % NUM_REQ])
                        gIdx = (modelPtr + k) % NUM_REQ;
                end
            end
            if (gIdx >= 0) expGnt[gIdx] = 1'b1;
            checkOutput("grant", 32'(reqRdy), 32'(expGnt));
            checkOutput("add_vld", 32'(addVld), 32'(prevAccept));
            if (prevAccept) begin
                checkOutput("add_a", addA, prevA);
                checkOutput("add_b", addB, prevB);
            end
            prevAccept = 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (reqVld[i] && reqRdy[i]) begin
                    r     = refAdd(reqA[32*i +: 32], reqB[32*i +: 32]);
                    e.id  = i;
                    e.res = r[31:0];
                    e.ovf = r[32];
                    expQ.push_back(e);
                    gntLog.push_back(i);
                    acceptCount++;
                    prevAccept = 1'b1;
                    prevA      = reqA[32*i +: 32];
                    prevB      = reqB[32*i +: 32];
                end
            end
            if (gIdx >= 0) begin
                modelPtr = (gIdx + 1) % NUM_REQ;
                modelOut = modelOut + 1;
            end
            if (rspVld && rspRdy) modelOut = modelOut - 1;
        end
    end

    // Response side: pops the scoreboard on every handshake.
    always @(negedge clk) begin : rspMonitor
        expRsp_t e;
        if (!rst) begin
            if (expQ.size() == 0) begin
                checkOutput("rsp_vld with nothing outstanding", 32'(rspVld), 32'd0);
            end else if (rspVld && rspRdy) begin
                e = expQ.pop_front();
                checkOutput("rsp_id",  32'(rspId),  32'(e.id));
                checkOutput("rsp_res", rspRes,      e.res);
                checkOutput("rsp_ovf", 32'(rspOvf), 32'(e.ovf));
                rspLog.push_back(int'(rspId));
            end
        end
    end

    initial begin
        int n;
        reqVld = '0;
        reqA   = '0;
        reqB   = '0;
        rspRdy = 1'b0;
        #1 rst = 1'b1;
        #11;
        checkResetOutputs("power-on reset");
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        $display("[TB] single request");
        applyStimulus(4'b0001, 1'b1);
        reqA[31:0] = 32'h3F800000;
        reqB[31:0] = 32'h40000000;
        @(negedge clk);
        checkOutput("single grant", 32'(reqRdy), 32'd1);
        applyStimulus('0, 1'b1);
        @(negedge clk);
        checkOutput("single add_vld T+1", 32'(addVld), 32'd1);
        checkOutput("single rsp_vld T+1", 32'(rspVld), 32'd0);
        @(negedge clk);
        checkOutput("single rsp_vld T+2", 32'(rspVld), 32'd0);
        @(negedge clk);
        checkOutput("single rsp_vld T+3", 32'(rspVld), 32'd1);
        checkOutput("single rsp_id",      32'(rspId),  32'd0);
        checkOutput("single rsp_res",     rspRes,      32'h40400000);
        checkOutput("single rsp_ovf",     32'(rspOvf), 32'd0);
        drain();

        $display("[TB] full contention");
        gntLog.delete();
        rspLog.delete();
        repeat (12) applyStimulus(4'hF, 1'b1);
        drain();
        checkOutput("contention accepts",   32'(gntLog.size()), 32'd12);
        checkOutput("contention responses", 32'(rspLog.size()), 32'd12);
        for (int k = 0; k < gntLog.size() && k < rspLog.size(); k++) begin
            checkOutput("contention grant order", 32'(gntLog[k]), 32'((gntLog[0] + k) % NUM_REQ));
            checkOutput("contention rsp_id order", 32'(rspLog[k]), 32'(gntLog[k]));
        end

        $display("[TB] backpressure");
        acceptCount = 0;
        repeat (10) applyStimulus(4'b0010, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("backpressure accepts", 32'(acceptCount), 32'd4);
        checkOutput("backpressure req_rdy", 32'(reqRdy), 32'd0);
        applyStimulus(4'b0010, 1'b1);
        @(negedge clk);
        #1;
        checkOutput("req_rdy during pop", 32'(reqRdy), 32'd0);
        applyStimulus(4'b0010, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("accept after pop", 32'(reqRdy), 32'b0010);
        repeat (4) applyStimulus(4'b0010, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("one extra accept", 32'(acceptCount), 32'd5);

        $display("[TB] accept and pop together");
        applyStimulus('0, 1'b1);
        @(negedge clk);
        #1;
        checkOutput("outstanding full", 32'(dut.outstanding_q), 32'd4);
        applyStimulus(4'b0100, 1'b1);
        @(negedge clk);
        #1;
        checkOutput("outstanding before both", 32'(dut.outstanding_q), 32'd3);
        checkOutput("grant with pop", 32'(reqRdy), 32'b0100);
        applyStimulus('0, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("outstanding after both", 32'(dut.outstanding_q), 32'd3);
        drain();

        $display("[TB] special case");
        applyStimulus(4'b0100, 1'b1);
        reqA[95:64] = 32'h7F800000;
        reqB[95:64] = 32'hFF800000;
        applyStimulus('0, 1'b1);
        n = 0;
        @(negedge clk);
        #1;
        while (!rspVld && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("special rsp_vld", 32'(rspVld), 32'd1);
        checkOutput("special rsp_id",  32'(rspId),  32'd2);
        checkOutput("special rsp_res", rspRes,      32'h7FC00000);
        checkOutput("special rsp_ovf", 32'(rspOvf), 32'd1);
        drain();

        $display("[TB] reset mid-flight");
        repeat (3) applyStimulus(4'hF, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkResetOutputs("mid-flight reset");
        expQ.delete();
        reqVld = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("rr_ptr after reset", 32'(dut.rr_ptr_q), 32'd0);
        repeat (6) begin
            @(negedge clk);
            #1;
            checkOutput("idle after reset", 32'(rspVld), 32'd0);
        end
        applyStimulus(4'hF, 1'b1);
        @(negedge clk);
        #1;
        checkOutput("pointer restarts at 0", 32'(reqRdy), 32'd1);
        drain();

        $display("[TB] random traffic");
        repeat (300) applyStimulus(NUM_REQ'($urandom), ($urandom_range(0, 9) < 7));
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
